// File: rtl/conv_ctrl_pkg.sv
// Shared types and default sizing for the convolutional-encoder frame sequencer.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    DATA = 2'd2,
    TAIL = 2'd3
  } state_t;

  localparam int TAIL_LEN_DEF      = 4;
  localparam int MAX_FRAME_LEN_DEF = 1024;
  localparam int LEN_W_DEF         = 11;
  localparam int CODE_W            = 2;

endpackage

// File: rtl/conv_frame_ctrl.sv
// Frames a serial bit stream into the 4-bit conv encoder: clear, data shifts, zero tail.
// Pair valid one cycle after each shift; out_ready low freezes the encoder and drops in_ready.
module conv_frame_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int TAIL_LEN      = TAIL_LEN_DEF,
  parameter int MAX_FRAME_LEN = MAX_FRAME_LEN_DEF,
  parameter int LEN_W         = LEN_W_DEF
) (
  input  logic              clk_sig,
  input  logic              rst_n,
  input  logic              in_bit,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              enc_q,
  output logic              enc_en_n,
  output logic              enc_clr,
  input  logic [CODE_W-1:0] enc_code,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              err_len
);

  localparam int TAIL_W = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
  localparam logic [LEN_W-1:0]  LEN_LIMIT = LEN_W'(MAX_FRAME_LEN - 1);
  localparam logic [TAIL_W-1:0] TAIL_END  = TAIL_W'(TAIL_LEN - 1);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [TAIL_W-1:0] tail_q;
  logic              slot;
  logic              shift;
  logic              last_shift;
  logic              len_overflow;

  // Shifting only into a free slot keeps enc_code frozen under a stalled pair.
  assign slot     = ~out_valid | out_ready;
  assign enc_en_n = ~shift;
  assign out_code = enc_code;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    enc_q        = 1'b0;
    enc_clr      = 1'b0;
    shift        = 1'b0;
    last_shift   = 1'b0;
    len_overflow = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = CLR;
      end
      CLR: begin
        enc_clr = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        in_ready = slot;
        if (slot && in_valid) begin
          shift = 1'b1;
          enc_q = in_bit;
          if (in_last || (len_q == LEN_LIMIT)) state_d = TAIL;
          len_overflow = ~in_last && (len_q == LEN_LIMIT);
        end
      end
      TAIL: begin
        if (slot) begin
          shift = 1'b1;
          if (tail_q == TAIL_END) begin
            last_shift = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      tail_q    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_cnt <= '0;
      err_len   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == CLR)
        len_q <= '0;
      else if (state_q == DATA && shift)
        len_q <= len_q + LEN_W'(1);

      if (state_q != TAIL)
        tail_q <= '0;
      else if (shift)
        tail_q <= tail_q + TAIL_W'(1);

      // A new shift always refills the output register, even when the old pair leaves this cycle.
      if (shift) begin
        out_valid <= 1'b1;
        out_last  <= last_shift;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (last_shift)   frame_cnt <= frame_cnt + 16'd1;
      if (len_overflow) err_len   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl with a behavioural 4-bit conv encoder alongside the DUT.
module tb_conv_frame_ctrl;

  localparam int TAIL = 4;
  localparam int MAXL = 1024;

  logic        clk_sig = 1'b0;
  logic        rst_n   = 1'b0;
  logic        in_bit  = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        enc_q;
  logic        enc_en_n;
  logic        enc_clr;
  logic [1:0]  enc_code;
  logic [1:0]  out_code;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_len;

  conv_frame_ctrl dut (
    .clk_sig  (clk_sig),
    .rst_n    (rst_n),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .enc_q    (enc_q),
    .enc_en_n (enc_en_n),
    .enc_clr  (enc_clr),
    .enc_code (enc_code),
    .out_code (out_code),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy),
    .frame_cnt(frame_cnt),
    .err_len  (err_len)
  );

  // Encoder register starts with junk so only enc_clr can make the first frame correct.
  logic [3:0] enc_r = 4'b1011;
  always @(posedge clk_sig) begin
    if (enc_clr)        enc_r <= 4'b0000;
    else if (!enc_en_n) enc_r <= {enc_q, enc_r[3:1]};
  end
  assign enc_code = {enc_r[3] ^ enc_r[1] ^ enc_r[0], enc_r[3] ^ enc_r[2] ^ enc_r[1] ^ enc_r[0]};

  initial forever #5 clk_sig = ~clk_sig;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         in_ready_cnt = 0;
  int         clr_cnt = 0;
  int         first_pair_cyc = -1;
  int         last_pair_cyc = -1;
  int         or_mode = 0;
  int         tog_idx = 0;
  bit         sb_en = 1'b1;
  bit         cap_en = 1'b0;
  bit         stall_prev = 1'b0;
  logic [1:0] held_code = 2'b00;
  logic       held_last = 1'b0;
  logic       stim[$];
  logic [2:0] exp_q[$];
  logic [2:0] cap_q[$];

  // {code[1], code[0], last}
  logic [2:0] lit1[$] = '{3'b110, 3'b010, 3'b110, 3'b110, 3'b001};
  logic [2:0] lit2[$] = '{3'b110, 3'b010, 3'b000, 3'b010, 3'b100, 3'b000,
                          3'b000, 3'b010, 3'b110, 3'b110, 3'b000, 3'b001};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: condition not met (cycle %0d)", nm, cyc);
  endtask

  // Code bit at time k of a frame: data bits followed by zeros, zero history before the clear.
  function automatic logic u(input logic fr[$], input int k);
    return (k >= 0 && k < fr.size()) ? fr[k] : 1'b0;
  endfunction

  task automatic emit_frame(input logic fr[$]);
    int n = fr.size() + TAIL;
    for (int t = 0; t < n; t++) begin
      logic c1, c0;
      c1 = u(fr, t) ^ u(fr, t - 2) ^ u(fr, t - 3);
      c0 = u(fr, t) ^ u(fr, t - 1) ^ u(fr, t - 2) ^ u(fr, t - 3);
      exp_q.push_back({c1, c0, (t == n - 1)});
    end
  endtask

  task automatic model_push();
    logic fr[$];
    for (int i = 0; i < stim.size(); i++) begin
      fr.push_back(stim[i]);
      if (fr.size() == MAXL || i == stim.size() - 1) begin
        emit_frame(fr);
        fr.delete();
      end
    end
  endtask

  // Entered and left at posedge+1; in_ready is judged at the negedge before the handshake edge.
  task automatic send_stim(input bit chk_delay);
    for (int i = 0; i < stim.size(); i++) begin
      int  waits = 0;
      bit  ok = 1'b0;
      in_valid = 1'b1;
      in_bit   = stim[i];
      in_last  = (i == stim.size() - 1);
      while (!ok && waits < 50) begin
        @(negedge clk_sig);
        ok = in_ready;
        if (!ok) waits++;
        @(posedge clk_sig);
        #1;
      end
      if (!ok) fail("in_ready_timeout");
      if (chk_delay && i == 0) chk("first_ready_delay", waits, 2);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input bit chk_delay);
    model_push();
    send_stim(chk_delay);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && k < budget) begin
      @(posedge clk_sig);
      #1;
      k++;
    end
    if (k >= budget) fail("drain_timeout");
  endtask

  task automatic check_cap(input string nm, input logic [2:0] lit[$]);
    chk({nm, "_count"}, cap_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < cap_q.size(); i++)
      chk($sformatf("%s_pair%0d", nm, i), cap_q[i], lit[i]);
    cap_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_in_ready"},  in_ready,  0);
    chk({nm, "_enc_q"},     enc_q,     0);
    chk({nm, "_enc_en_n"},  enc_en_n,  1);
    chk({nm, "_enc_clr"},   enc_clr,   0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_last"},  out_last,  0);
    chk({nm, "_busy"},      busy,      0);
    chk({nm, "_frame_cnt"}, frame_cnt, 0);
    chk({nm, "_err_len"},   err_len,   0);
  endtask

  initial forever begin
    @(posedge clk_sig);
    #1;
    out_ready = (or_mode == 0) ? 1'b1 : (tog_idx == 0 || tog_idx == 3);
    tog_idx   = (tog_idx + 1) % 4;
  end

  always @(negedge clk_sig) begin
    cyc++;
    if (rst_n && sb_en) begin
      if (stall_prev && out_valid) begin
        chk("hold_code", out_code, held_code);
        chk("hold_last", out_last, held_last);
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_enc_en_n", enc_en_n, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_pair");
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          chk("pair_code", out_code, e[2:1]);
          chk("pair_last", out_last, e[0]);
        end
        if (cap_en) cap_q.push_back({out_code, out_last});
        if (first_pair_cyc < 0) first_pair_cyc = cyc;
        last_pair_cyc = cyc;
      end
    end
    stall_prev = rst_n && out_valid && !out_ready;
    held_code  = out_code;
    held_last  = out_last;
    if (in_ready) in_ready_cnt++;
    if (enc_clr)  clr_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc0, cc0;
    repeat (3) @(posedge clk_sig);
    @(negedge clk_sig);
    check_reset_outputs("reset");
    @(posedge clk_sig);
    #1;
    rst_n = 1'b1;
    @(posedge clk_sig);
    #1;

    // single-bit frame
    stim = '{1'b1};
    cap_q.delete(); cap_en = 1'b1;
    run_frame(1'b1);
    drain(100);
    check_cap("one_bit", lit1);
    chk("frame_cnt_t1", frame_cnt, 1);

    // 8-bit frame, continuous ready
    stim = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    cap_q.delete(); cap_en = 1'b1;
    rc0 = in_ready_cnt;
    first_pair_cyc = -1;
    run_frame(1'b1);
    drain(100);
    check_cap("eight_bit", lit2);
    chk("in_ready_cycles", in_ready_cnt - rc0, 8);
    chk("pair_span", last_pair_cyc - first_pair_cyc, 11);
    chk("frame_cnt_t2", frame_cnt, 2);

    // same frame under 1,0,0,1 ready pattern
    or_mode = 1;
    cap_q.delete(); cap_en = 1'b1;
    run_frame(1'b0);
    drain(200);
    or_mode = 0;
    check_cap("stalled", lit2);
    chk("frame_cnt_t3", frame_cnt, 3);

    // over-length frame
    chk("err_len_before", err_len, 0);
    stim.delete();
    for (int i = 0; i < MAXL + 3; i++)
      stim.push_back(((i % 3) == 0) ^ (((i / 5) % 2) == 1));
    run_frame(1'b1);
    drain(3000);
    chk("err_len_after", err_len, 1);
    chk("frame_cnt_t4", frame_cnt, 5);

    // back-to-back 3-bit frames
    cc0 = clr_cnt;
    stim = '{1'b1, 1'b0, 1'b1};
    run_frame(1'b1);
    stim = '{1'b1, 1'b1, 1'b0};
    run_frame(1'b0);
    drain(100);
    chk("clr_pulses", clr_cnt - cc0, 2);
    chk("frame_cnt_t5", frame_cnt, 7);

    // reset in the middle of DATA
    sb_en    = 1'b0;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    in_last  = 1'b0;
    repeat (5) @(posedge clk_sig);
    #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    in_valid = 1'b0;
    @(posedge clk_sig);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    sb_en = 1'b1;
    @(posedge clk_sig);
    #1;
    stim = '{1'b1};
    cap_q.delete(); cap_en = 1'b1;
    run_frame(1'b1);
    drain(100);
    check_cap("post_reset", lit1);
    chk("frame_cnt_t6", frame_cnt, 1);
    chk("err_len_t6", err_len, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
